// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared core definitions used by the memory arbiter: FSM and owner encodings,
// plus the size of the word-addressed memory.
package mips32_pkg;

  localparam int MEM_WORDS = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bundle of fetch port, data port and memory-side signals of the arbiter.
// Handshake: a requester holds *_req with its address/data stable until *_gnt is seen high
// in the same cycle; *_rvalid is a one-cycle pulse that needs no acknowledge.
interface mips32_mem_arbiter_if import mips32_pkg::*; #(
  parameter int AW = 10
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  arb_state_e    dbg_state;
  logic [7:0]    dbg_starve_cnt;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state, dbg_starve_cnt
  );

  // Core pipeline and memory side
  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state, dbg_starve_cnt
  );

endinterface

// File: rtl/mips32_arb_pick.sv
// Winner select for the memory arbiter: data port first, unless fetch has been passed
// over STARVE_MAX times in a row while waiting.
module mips32_arb_pick #(
  parameter int STARVE_MAX = 3,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          idle_i,
  input  logic          if_req_i,
  input  logic          if_flush_i,
  input  logic          dm_req_i,
  output logic          if_win_o,
  output logic          dm_win_o,
  output logic [SW-1:0] starve_cnt_o
);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starve_full;

  assign starve_full  = (starve_q == SW'(STARVE_MAX));
  assign starve_cnt_o = starve_q;

  always_comb begin
    if_win_o = idle_i && if_req_i && !if_flush_i && (!dm_req_i || starve_full);
    dm_win_o = idle_i && dm_req_i && !if_win_o;
    starve_d = starve_q;
    // Only a fetch that is really waiting (not being flushed) counts as passed over.
    if (!if_req_i || if_win_o) begin
      starve_d = '0;
    end else if (dm_win_o && !if_flush_i && !starve_full) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port word memory shared by instruction fetch and the MEM stage; one transaction
// outstanding at a time, sequenced IDLE -> ISSUE -> (WAIT for reads) -> IDLE.
module mips32_mem_arbiter import mips32_pkg::*; #(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk1,
  input logic                 rst,
  mips32_mem_arbiter_if.slave bus
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q;
  arb_owner_e    owner_q;
  logic [LW-1:0] lat_q;
  logic          rsp_q;
  logic          flushed_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          if_rvalid_q;
  logic [31:0]   if_rdata_q;
  logic          dm_rvalid_q;
  logic [31:0]   dm_rdata_q;

  logic          if_win;
  logic          dm_win;
  logic [SW-1:0] starve_cnt;

  mips32_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .clk1         (clk1),
    .rst          (rst),
    .idle_i       (state_q == ARB_IDLE),
    .if_req_i     (bus.if_req),
    .if_flush_i   (bus.if_flush),
    .dm_req_i     (bus.dm_req),
    .if_win_o     (if_win),
    .dm_win_o     (dm_win),
    .starve_cnt_o (starve_cnt)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      rsp_q       <= 1'b0;
      flushed_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      // A flush seen at any point of an IF transaction kills its response.
      if (owner_q == OWN_IF && state_q != ARB_IDLE && bus.if_flush) begin
        flushed_q <= 1'b1;
      end
      case (state_q)
        ARB_IDLE: begin
          flushed_q <= 1'b0;
          if (if_win) begin
            state_q     <= ARB_ISSUE;
            owner_q     <= OWN_IF;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end else if (dm_win) begin
            state_q     <= ARB_ISSUE;
            owner_q     <= OWN_DM;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
          end
        end
        ARB_ISSUE: begin
          if (mem_we_q) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_WAIT;
            lat_q   <= LW'(MEM_LAT - 1);
            rsp_q   <= 1'b0;
          end
        end
        ARB_WAIT: begin
          // rsp_q marks the cycle the rvalid pulse is out; IDLE follows it.
          if (rsp_q) begin
            state_q <= ARB_IDLE;
            rsp_q   <= 1'b0;
          end else if (lat_q == '0) begin
            rsp_q <= 1'b1;
            if (owner_q == OWN_DM) begin
              dm_rdata_q  <= bus.mem_rdata;
              dm_rvalid_q <= 1'b1;
            end else if (!flushed_q && !bus.if_flush) begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.if_gnt         = if_win;
  assign bus.dm_gnt         = dm_win;
  assign bus.if_rvalid      = if_rvalid_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.dm_rvalid      = dm_rvalid_q;
  assign bus.dm_rdata       = dm_rdata_q;
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_starve_cnt = 8'(starve_cnt);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed timing scenarios plus a random mix, with a
// reference memory feeding per-port expected-data queues.
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int AW         = 10;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mips32_mem_arbiter_if #(.AW(AW)) bus ();

  mips32_mem_arbiter #(
    .AW         (AW),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) u_dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'h2820_0001;
    return {16'hC0DE ^ a[15:0], a[15:0]};
  endfunction

  // ---------------- memory model (MEM_LAT read pipeline) ----------------
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_pipe [MEM_LAT];
  logic        mem_ready = 1'b0;

  always @(posedge clk1) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'h0BAD_0BAD;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- scoreboard state ----------------
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];
  logic [31:0] if_last_exp, dm_last_exp;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int if_rv_cnt = 0;
  int dm_rv_cnt = 0;

  logic        s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mem_en, s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [31:0] s_mem_wdata, s_if_rdata, s_dm_rdata;
  logic [1:0]  s_state;
  logic [7:0]  s_starve;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: sample at negedge, score responses, record grants, then move to
  // just after the next posedge where the caller drives the following cycle's inputs.
  task automatic tick();
    @(negedge clk1);
    s_if_gnt    = bus.if_gnt;
    s_dm_gnt    = bus.dm_gnt;
    s_if_rv     = bus.if_rvalid;
    s_dm_rv     = bus.dm_rvalid;
    s_if_rdata  = bus.if_rdata;
    s_dm_rdata  = bus.dm_rdata;
    s_mem_en    = bus.mem_en;
    s_mem_we    = bus.mem_we;
    s_mem_addr  = bus.mem_addr;
    s_mem_wdata = bus.mem_wdata;
    s_state     = bus.dbg_state;
    s_starve    = bus.dbg_starve_cnt;
    if (s_if_rv) begin
      if_rv_cnt++;
      if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        if_last_exp = if_exp_q.pop_front();
        check("if_rdata", s_if_rdata, if_last_exp);
      end
    end
    if (s_dm_rv) begin
      dm_rv_cnt++;
      if (dm_exp_q.size() == 0) check("dm_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        dm_last_exp = dm_exp_q.pop_front();
        check("dm_rdata", s_dm_rdata, dm_last_exp);
      end
    end
    if (s_if_gnt) if_exp_q.push_back(ref_mem[bus.if_addr]);
    if (s_dm_gnt) begin
      if (bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
      else           dm_exp_q.push_back(ref_mem[bus.dm_addr]);
    end
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    if_exp_q.delete();
    dm_exp_q.delete();
    if_last_exp = '0;
    dm_last_exp = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv0, dm_grants, max_starve, budget;
    bit got_if, want_if, want_dm;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    do_reset(3);

    // Reset values
    check("rst_mem_en",    32'(s_mem_en), 0);
    check("rst_mem_we",    32'(s_mem_we), 0);
    check("rst_mem_addr",  32'(s_mem_addr), 0);
    check("rst_mem_wdata", s_mem_wdata, 0);
    check("rst_if_rvalid", 32'(s_if_rv), 0);
    check("rst_dm_rvalid", 32'(s_dm_rv), 0);
    check("rst_if_rdata",  s_if_rdata, 0);
    check("rst_dm_rdata",  s_dm_rdata, 0);
    check("rst_state",     32'(s_state), 32'(ARB_IDLE));
    check("rst_starve",    32'(s_starve), 0);
    tick();

    // 1: lone fetch of word 5
    bus.if_req = 1'b1; bus.if_addr = AW'(5);
    tick();
    check("t1_if_gnt", 32'(s_if_gnt), 1);
    check("t1_dm_gnt", 32'(s_dm_gnt), 0);
    bus.if_req = 1'b0;
    tick();
    check("t1_mem_en",   32'(s_mem_en), 1);
    check("t1_mem_addr", 32'(s_mem_addr), 5);
    check("t1_mem_we",   32'(s_mem_we), 0);
    tick();
    check("t1_mem_en_once", 32'(s_mem_en), 0);
    check("t1_rv_early",    32'(s_if_rv), 0);
    tick();
    check("t1_if_rvalid", 32'(s_if_rv), 1);
    check("t1_if_rdata",  s_if_rdata, 32'h2820_0001);
    tick();
    check("t1_rv_pulse", 32'(s_if_rv), 0);

    // 2: simultaneous fetch and LW 10, data port first
    bus.if_req = 1'b1; bus.if_addr = AW'(3);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(10);
    tick();
    check("t2_dm_gnt", 32'(s_dm_gnt), 1);
    check("t2_if_gnt", 32'(s_if_gnt), 0);
    bus.dm_req = 1'b0;
    tick();
    check("t2_starve_one", 32'(s_starve), 1);
    check("t2_if_blocked1", 32'(s_if_gnt), 0);
    tick();
    check("t2_if_blocked2", 32'(s_if_gnt), 0);
    tick();
    check("t2_dm_rvalid", 32'(s_dm_rv), 1);
    check("t2_if_blocked3", 32'(s_if_gnt), 0);
    tick();
    check("t2_if_gnt_t4", 32'(s_if_gnt), 1);
    bus.if_req = 1'b0;
    tick();
    check("t2_starve_clr", 32'(s_starve), 0);
    repeat (3) tick();

    // 3: continuous stores starve fetch; IF forced in after STARVE_MAX DM grants
    dm_grants = 0; got_if = 1'b0; max_starve = 0;
    bus.if_req = 1'b1; bus.if_addr = AW'(20);
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = AW'(100); bus.dm_wdata = $urandom;
    for (int k = 0; k < 40 && !got_if; k++) begin
      tick();
      if (int'(s_starve) > max_starve) max_starve = int'(s_starve);
      if (s_dm_gnt) begin
        dm_grants++;
        bus.dm_addr  = bus.dm_addr + AW'(1);
        bus.dm_wdata = $urandom;
      end
      if (s_if_gnt) begin
        got_if = 1'b1;
        bus.if_req = 1'b0;
      end
    end
    bus.dm_req = 1'b0;
    check("t3_if_won", 32'(got_if), 1);
    check("t3_dm_grants_before_if", 32'(dm_grants), STARVE_MAX);
    check("t3_starve_max", 32'(max_starve), STARVE_MAX);
    tick();
    check("t3_starve_back_to_0", 32'(s_starve), 0);
    repeat (4) tick();

    // 4: SW 7 = DEADBEEF, then LW 7 as soon as allowed
    rv0 = dm_rv_cnt;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = AW'(7); bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("t4_dm_gnt", 32'(s_dm_gnt), 1);
    bus.dm_we = 1'b0; bus.dm_wdata = '0;
    tick();
    check("t4_mem_en",    32'(s_mem_en), 1);
    check("t4_mem_we",    32'(s_mem_we), 1);
    check("t4_mem_addr",  32'(s_mem_addr), 7);
    check("t4_mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
    check("t4_no_gnt_busy", 32'(s_dm_gnt), 0);
    tick();
    check("t4_regrant_2cyc", 32'(s_dm_gnt), 1);
    check("t4_no_rvalid_store", 32'(dm_rv_cnt), 32'(rv0));
    bus.dm_req = 1'b0;
    repeat (4) tick();
    check("t4_readback_count", 32'(dm_rv_cnt), 32'(rv0 + 1));
    check("t4_readback_data", s_dm_rdata, 32'hDEAD_BEEF);

    // 5a/5b: fetch flushed in ISSUE, then on the capture cycle; queued LW waits for IDLE
    for (int v = 0; v < 2; v++) begin
      bus.if_req = 1'b1; bus.if_addr = AW'(30 + v);
      tick();
      check("t5_if_gnt", 32'(s_if_gnt), 1);
      bus.if_req = 1'b0;
      if (s_if_gnt) void'(if_exp_q.pop_back());
      rv0 = if_rv_cnt;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(40 + v);
      bus.if_flush = (v == 0);
      tick();
      bus.if_flush = (v == 1);
      check("t5_dm_wait_issue", 32'(s_dm_gnt), 0);
      tick();
      bus.if_flush = 1'b0;
      tick();
      check("t5_if_rvalid_suppressed", 32'(s_if_rv), 0);
      check("t5_dm_wait_rsp", 32'(s_dm_gnt), 0);
      tick();
      check("t5_dm_gnt_next_idle", 32'(s_dm_gnt), 1);
      check("t5_if_rdata_held", s_if_rdata, if_last_exp);
      bus.dm_req = 1'b0;
      repeat (4) tick();
      check("t5_if_rvalid_count", 32'(if_rv_cnt), 32'(rv0));
    end

    // 5c: flush in IDLE masks the fetch request for that cycle
    bus.if_req = 1'b1; bus.if_addr = AW'(33); bus.if_flush = 1'b1;
    tick();
    check("t5c_flush_masks_gnt", 32'(s_if_gnt), 0);
    bus.if_flush = 1'b0;
    tick();
    check("t5c_gnt_after_flush", 32'(s_if_gnt), 1);
    bus.if_req = 1'b0;
    repeat (4) tick();

    // 5d: flush during a load does not touch the DM response
    rv0 = dm_rv_cnt;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(50);
    tick();
    check("t5d_dm_gnt", 32'(s_dm_gnt), 1);
    bus.dm_req = 1'b0;
    tick();
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    tick();
    check("t5d_dm_rvalid", 32'(s_dm_rv), 1);
    tick();
    check("t5d_dm_count", 32'(dm_rv_cnt), 32'(rv0 + 1));

    // 6: reset in WAIT drops the fetch
    rv0 = if_rv_cnt;
    bus.if_req = 1'b1; bus.if_addr = AW'(60);
    tick();
    check("t6_if_gnt", 32'(s_if_gnt), 1);
    bus.if_req = 1'b0;
    tick();
    do_reset(1);
    tick();
    check("t6_rst_mem_en",    32'(s_mem_en), 0);
    check("t6_rst_mem_addr",  32'(s_mem_addr), 0);
    check("t6_rst_if_rvalid", 32'(s_if_rv), 0);
    check("t6_rst_if_rdata",  s_if_rdata, 0);
    check("t6_rst_dm_rdata",  s_dm_rdata, 0);
    check("t6_rst_state",     32'(s_state), 32'(ARB_IDLE));
    repeat (3) tick();
    check("t6_no_rvalid_dropped", 32'(if_rv_cnt), 32'(rv0));
    bus.if_req = 1'b1; bus.if_addr = AW'(5);
    tick();
    check("t6_fresh_gnt", 32'(s_if_gnt), 1);
    bus.if_req = 1'b0;
    repeat (4) tick();

    // Random mix of fetches, loads and stores, both ports often competing
    for (int n = 0; n < 30; n++) begin
      want_if = 1'($urandom_range(0, 1));
      want_dm = !want_if || 1'($urandom_range(0, 1));
      bus.if_req   = want_if;
      bus.if_addr  = AW'($urandom_range(0, MEM_WORDS - 1));
      bus.dm_req   = want_dm;
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_addr  = AW'($urandom_range(0, 15));
      bus.dm_wdata = $urandom;
      budget = 0;
      while ((bus.if_req || bus.dm_req) && budget < 50) begin
        tick();
        budget++;
        if (s_if_gnt) bus.if_req = 1'b0;
        if (s_dm_gnt) bus.dm_req = 1'b0;
      end
      if (bus.if_req || bus.dm_req) check("rand_gnt_timeout", 32'd0, 32'd1);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
    repeat (8) tick();

    // ---------------- final report ----------------
    check("if_queue_drained", 32'(if_exp_q.size()), 0);
    check("dm_queue_drained", 32'(dm_exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
